exception_request_gen: RTL

//  Source side of the CPU exception-request interface: converts three raw, bouncy

---
 rtl/exception_request_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/exception_request_gen.sv
// rtl/exception_request_gen.sv - debounced one-hot exception request source for CP0
//
// Turns three raw, bouncy request inputs into clean one-hot expsrc0..2 requests and
// handshakes with CP0: has_exp takes the request, is_eret ends the handler.
// Only one request is in flight at a time; source 0 has the highest priority.
//
// Optional feature macro: EXP_REQ_CNT_EN adds o_req_cnt, the per-source counts of
// taken requests (11 bits each, saturating at 2047).
//
// Ports:
//   i_clk         system clock, all state updates on posedge
//   i_reset       asynchronous, active-high reset
//   i_src_in[2:0] raw request inputs, asynchronous to i_clk; bit i -> o_expsrc i
//   i_has_exp     CP0 took the exception (acknowledge)
//   i_is_eret     eret executing (handler finished)
//   i_exp_block   exceptions masked
//   o_expsrc0..2  registered one-hot requests (0 = highest priority)
//   o_pending     latched requests not yet taken
//   o_busy        request outstanding or handler running
//   o_req_cnt     {cnt2,cnt1,cnt0} taken-request counts (EXP_REQ_CNT_EN only)

module exception_request_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_src_in,
    input  logic       i_has_exp,
    input  logic       i_is_eret,
    input  logic       i_exp_block,
    output logic       o_expsrc0,
    output logic       o_expsrc1,
    output logic       o_expsrc2,
    output logic [2:0] o_pending,
    output logic       o_busy
`ifdef EXP_REQ_CNT_EN
    ,
    output logic [32:0] o_req_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_db;
    logic [2:0]       r_db_d;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_pending;
    logic [2:0]       r_expsrc;
    logic [1:0]       r_sel;
    state_t           r_state;

    logic [2:0]       w_rise;
    logic [2:0]       w_clr;
    logic [1:0]       w_first;
    logic             w_take;

    // Synchronizer and per-bit debounce. The counter tracks how many consecutive
    // cycles the synchronized input has disagreed with the accepted level; any
    // agreeing cycle restarts it, so short pulses never reach r_db.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_src_in;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_LAST) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only rising debounced edges raise requests; a held input is one request.
    assign w_rise = r_db & ~r_db_d;

    always_comb begin
        w_first = 2'd2;
        if (r_pending[0]) begin
            w_first = 2'd0;
        end else if (r_pending[1]) begin
            w_first = 2'd1;
        end
    end

    // exp_block has priority over has_exp while a request is presented.
    assign w_take = (r_state == ST_REQ) && !i_exp_block && i_has_exp;
    assign w_clr  = w_take ? (3'b001 << r_sel) : 3'b000;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_expsrc  <= '0;
            r_pending <= '0;
        end else begin
            // A new edge on the bit being taken in this cycle survives the clear.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            case (r_state)
                ST_IDLE: begin
                    if ((|r_pending) && !i_exp_block) begin
                        r_sel    <= w_first;
                        r_expsrc <= 3'b001 << w_first;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_exp_block) begin
                        r_expsrc <= '0;
                        r_state  <= ST_IDLE;
                    end else if (i_has_exp) begin
                        r_expsrc <= '0;
                        r_state  <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    r_expsrc <= '0;
                    if (i_is_eret) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_expsrc <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_expsrc0 = r_expsrc[0];
    assign o_expsrc1 = r_expsrc[1];
    assign o_expsrc2 = r_expsrc[2];
    assign o_pending = r_pending;
    assign o_busy    = (r_state != ST_IDLE);

`ifdef EXP_REQ_CNT_EN
    logic [10:0] r_req_cnt [3];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) begin
                r_req_cnt[i] <= '0;
            end
        end else if (w_take && (r_req_cnt[r_sel] != 11'h7FF)) begin
            r_req_cnt[r_sel] <= r_req_cnt[r_sel] + 11'd1;
        end
    end

    assign o_req_cnt = {r_req_cnt[2], r_req_cnt[1], r_req_cnt[0]};
`endif

endmodule
